// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: control-field layout,
// the default bubble kill mask and the stage occupancy encodings.
package pipe_pkg;

    // Control field layout (LSB first)
    localparam int CTRL_W_DEF = 9;
    localparam int BF_BIT     = 0;   // branch
    localparam int WER_BIT    = 1;   // register-file write enable
    localparam int WEM_BIT    = 2;   // memory write enable
    localparam int AS_BIT     = 3;   // ALU operand select
    localparam int RS_LSB     = 4;   // result select
    localparam int RS_W       = 2;
    localparam int AC_LSB     = 6;   // ALU op code
    localparam int AC_W       = 3;

    // Bits that must read as zero whenever the stage holds a bubble
    localparam logic [CTRL_W_DEF-1:0] CTRL_KILL_MASK_DEF =
        CTRL_W_DEF'((1 << BF_BIT) | (1 << WER_BIT) | (1 << WEM_BIT));

    // Occupancy of the stage as seen by the handshake logic
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the stage: valid bit plus data and control payload.
// clr drops the entry (payload is kept); load captures a new payload.
module pipe_slot #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CTRL_W-1:0] ld_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;

    // Next entry contents: clear wins over load, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            ctrl_d  = ld_ctrl;
        end
    end

    // Entry registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// bubble control masking, optional skid entry and a saturating count of
// valid entries discarded by flushes.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W         = 96,
    parameter int                CTRL_W         = 9,
    parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = CTRL_W'(CTRL_KILL_MASK_DEF),
    parameter bit                SKID           = 1'b1,
    parameter int                CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  kill_cnt
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data, main_src_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
    logic              main_load, main_clr, skid_load, skid_clr;
    logic              in_fire, out_fire;
    state_e            st;
    logic [CNT_W-1:0]  kill_cnt_d, kill_cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v & out_ready;

    // Current occupancy derived from the two entry valid bits
    always_comb begin
        st = ST_EMPTY;
        if (skid_v)      st = ST_TWO;
        else if (main_v) st = ST_ONE;
    end

    // Entry load/clear decisions; flush overrides any transfer this cycle
    always_comb begin
        main_load     = 1'b0;
        main_clr      = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        main_src_data = skid_v ? skid_data : in_data;
        main_src_ctrl = skid_v ? skid_ctrl : in_ctrl;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (st)
                ST_EMPTY: main_load = in_fire;
                ST_ONE: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & ~out_fire;
                    main_clr  = out_fire & ~in_fire;
                end
                ST_TWO: begin
                    main_load = out_fire;
                    skid_clr  = out_fire;
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clr     (main_clr),
        .ld_data (main_src_data),
        .ld_ctrl (main_src_ctrl),
        .valid   (main_v),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            logic rdy_d, rdy_q;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clr     (skid_clr),
                .ld_data (in_data),
                .ld_ctrl (in_ctrl),
                .valid   (skid_v),
                .data    (skid_data),
                .ctrl    (skid_ctrl)
            );

            // Ready for next cycle is the inverse of the next skid valid bit
            always_comb begin
                rdy_d = flush | ~(skid_v ? ~out_fire : skid_load);
            end

            // Registered in_ready keeps out_ready off the upstream path
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rdy_q <= 1'b1;
                else     rdy_q <= rdy_d;
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign skid_v    = 1'b0;
            assign skid_data = '0;
            assign skid_ctrl = '0;
            assign in_ready  = ~main_v | out_ready;
        end
    endgenerate

    // Flush adds the number of entries held before the edge, saturating
    always_comb begin
        kill_cnt_d = kill_cnt_q;
        if (flush) kill_cnt_d = sat_add(kill_cnt_q, occupancy);
    end

    // Kill counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) kill_cnt_q <= '0;
        else     kill_cnt_q <= kill_cnt_d;
    end

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_v ? main_ctrl : (main_ctrl & ~CTRL_KILL_MASK);
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign kill_cnt  = kill_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and bubble insertion. It replaces the ad-hoc per-stage flip-flops between IF/ID/EX/MEM/WB.
The payload is split into a data field (operands, immediate) and a control field (branch, write enables, ALU op). Selected control bits are forced to zero whenever the stage holds a bubble.
An optional skid entry gives full throughput with a registered in_ready. A saturating counter reports how many valid instructions flushes have discarded.

Parameters:
DATA_W, 96, width of data field (e.g. A, B, IMM = 3x32)
CTRL_W, 9, width of control field
CTRL_KILL_MASK, 9'h007, control bits forced to 0 on out_ctrl when out_valid=0 (branch, reg write, mem write)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 8, width of kill counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage accepts this cycle
in_data  in  DATA_W  upstream data field
in_ctrl  in  CTRL_W  upstream control field
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts; 0 = stall
out_data  out  DATA_W  main entry data
out_ctrl  out  CTRL_W  main entry control; killed bits masked when out_valid=0
occupancy  out  2  number of valid entries (0..2)
kill_cnt  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Reset (async, rst=1): all valids 0, data/ctrl regs 0, occupancy 0, kill_cnt 0. in_ready=1 for SKID=1 (registered); follows the SKID=0 equation otherwise.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_data/in_ctrl are sampled only on in_fire. out_* hold stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from in_fire into an empty stage to out_valid=1. Throughput is 1 per cycle while out_ready=1. Order is strict FIFO.
- SKID=1 states (main/skid valid bits):
  - EMPTY: in_fire -> ONE (load main).
  - ONE:
    - in_fire & out_fire -> ONE (main <= input)
    - in_fire & !out_fire -> TWO (skid <= input)
    - !in_fire & out_fire -> EMPTY
  - TWO: in_ready=0.
    - out_fire -> ONE (main <= skid)
  - in_ready is registered and equals the next-state value of !skid_valid.
- SKID=0: in_ready = !out_valid | out_ready (combinational). States are EMPTY and ONE only. occupancy is never 2.
- Bubble: when out_valid=0, out_ctrl = ctrl_reg & ~CTRL_KILL_MASK. Bits outside the mask show the held value. out_data holds its last value (don't-care downstream).
- Flush (sampled on clk edge, highest priority):
  - next state EMPTY, regardless of in_fire or out_fire that cycle; any input accepted that cycle is dropped.
  - kill_cnt += number of valid entries held before the edge (0..2), saturating at 2^CNT_W-1.
  - in_ready is 1 on the following cycle.
  - out_fire in the flush cycle still counts as consumed downstream.
- Flush while stalled in TWO discards both entries and adds 2 to kill_cnt.
- rst asserted mid-operation: immediate EMPTY. kill_cnt clears and does not count the discarded entries.
- No combinational path from out_ready to in_ready when SKID=1.

Decomposition:
- Package pipe_pkg:
  - CTRL field offsets/widths: AC[2:0], RS[1:0], BF, WEM, WER, AS
  - default CTRL_KILL_MASK
  - localparam state encodings EMPTY/ONE/TWO
- One sub-module, pipe_slot: a valid+data+ctrl register with load and clear enables. It is instantiated as main and skid (skid only when SKID=1).
- Handshake/state logic and kill counter live in pipe_stage_reg.

Test Plan:
- Streaming, SKID=1: in_valid=1 with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles starting 1 cycle after first in_fire; occupancy stays 1.
- Stall: load 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB, no loss or duplication.
- Flush in TWO with in_valid=1 (data 0xC) same cycle -> next cycle out_valid=0, occupancy 0, kill_cnt=2, in_ready=1; 0xC never appears.
- Bubble masking: ctrl_reg=9'h1FF then flush -> out_ctrl=9'h1F8 while out_valid=0.
- Saturation: CNT_W=2, four single-entry flushes -> kill_cnt 1,2,3,3.
- SKID=0 plus async reset: stream with out_ready toggling -> in_ready tracks !out_valid|out_ready; assert rst mid-stream between clock edges -> out_valid=0, kill_cnt=0 immediately.
